// File: rtl/cpu_ad48_csr_ctrl_pkg.sv
// Shared constants for the AD48 CSR controller: CSR addresses, op codes, privilege encodings
// and address-decode helpers.
package cpu_ad48_csr_ctrl_pkg;

  localparam logic [11:0] CSR_ADDR_STATUS  = 12'h000;
  localparam logic [11:0] CSR_ADDR_SCRATCH = 12'h001;
  localparam logic [11:0] CSR_ADDR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_ADDR_INSTRET = 12'hC02;

  typedef enum logic [1:0] {
    CSR_F_R  = 2'd0,
    CSR_F_RW = 2'd1,
    CSR_F_RS = 2'd2,
    CSR_F_RC = 2'd3
  } csr_func_e;

  localparam logic [1:0] PRIV_U    = 2'b00;
  localparam logic [1:0] PRIV_S    = 2'b01;
  localparam logic [1:0] PRIV_M    = 2'b11;
  localparam logic [1:0] PRIV_RSVD = 2'b10;

  function automatic logic csr_addr_valid(input logic [11:0] addr);
    case (addr)
      CSR_ADDR_STATUS, CSR_ADDR_SCRATCH, CSR_ADDR_CYCLE, CSR_ADDR_INSTRET: csr_addr_valid = 1'b1;
      default: csr_addr_valid = 1'b0;
    endcase
  endfunction

  function automatic logic csr_addr_ro(input logic [11:0] addr);
    case (addr)
      CSR_ADDR_CYCLE, CSR_ADDR_INSTRET: csr_addr_ro = 1'b1;
      default: csr_addr_ro = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ad48_csr_arb.sv
// Two-way core/debug arbiter: core has priority until the debug side has lost STARVE_MAX
// consecutive times, then debug is force-granted for one cycle.
module cpu_ad48_csr_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic core_valid,
  input  logic dbg_valid,
  output logic core_grant,
  output logic dbg_grant,
  output logic core_ready,
  output logic dbg_ready
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_r;
  logic          force_dbg_s;

  // grant and ready decode; readies depend only on the valids and the starve count
  always_comb begin
    force_dbg_s = dbg_valid && (starve_r >= STARVE_LIM);
    core_grant  = core_valid && !force_dbg_s;
    dbg_grant   = dbg_valid && !core_grant;
    core_ready  = !force_dbg_s;
    dbg_ready   = force_dbg_s || !core_valid;
  end

  // starve counter: counts core wins while debug waits, clears on debug grant or debug idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_r <= {CW{1'b0}};
    end else if (dbg_grant || !dbg_valid) begin
      starve_r <= {CW{1'b0}};
    end else if (core_grant && (starve_r < STARVE_LIM)) begin
      starve_r <= starve_r + CW'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

endmodule

// File: rtl/cpu_ad48_csr_ctrl.sv
// AD48 CSR file (STATUS, SCRATCH, CYCLE, INSTRET) with single-cycle R/RW/RS/RC access.
// Define CPU_AD48_CSR_DBG_PORT_EN to enable the debug requester and its arbiter.
module cpu_ad48_csr_ctrl
  import cpu_ad48_csr_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN         = 48,
  parameter int unsigned     STARVE_MAX   = 4,
  parameter logic [XLEN-1:0] STATUS_RESET = 48'h3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            core_req_valid,
  output logic            core_req_ready,
  input  logic [1:0]      core_req_func,
  input  logic [11:0]     core_req_addr,
  input  logic [XLEN-1:0] core_req_wdata,
  output logic            core_resp_valid,
  output logic [XLEN-1:0] core_resp_rdata,
  output logic            core_resp_err,
  input  logic            dbg_req_valid,
  output logic            dbg_req_ready,
  input  logic [1:0]      dbg_req_func,
  input  logic [11:0]     dbg_req_addr,
  input  logic [XLEN-1:0] dbg_req_wdata,
  output logic            dbg_resp_valid,
  output logic [XLEN-1:0] dbg_resp_rdata,
  output logic            dbg_resp_err,
  input  logic            retire,
  output logic [1:0]      priv_mode,
  output logic [XLEN-1:0] csr_status,
  output logic [XLEN-1:0] csr_cycle
);

  logic [XLEN-1:0] status_r, scratch_r, cycle_r, instret_r;
  logic            core_resp_valid_r, core_resp_err_r;
  logic [XLEN-1:0] core_resp_rdata_r;
  logic            core_grant_s, dbg_grant_s, accept_s;
  csr_func_e       sel_func_s;
  logic [11:0]     sel_addr_s;
  logic [XLEN-1:0] sel_wdata_s, old_s, new_s, status_new_s;
  logic            err_s, wr_en_s;

`ifdef CPU_AD48_CSR_DBG_PORT_EN
  logic            dbg_resp_valid_r, dbg_resp_err_r;
  logic [XLEN-1:0] dbg_resp_rdata_r;

  cpu_ad48_csr_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .core_valid (core_req_valid),
    .dbg_valid  (dbg_req_valid),
    .core_grant (core_grant_s),
    .dbg_grant  (dbg_grant_s),
    .core_ready (core_req_ready),
    .dbg_ready  (dbg_req_ready)
  );

  assign dbg_resp_valid = dbg_resp_valid_r;
  assign dbg_resp_rdata = dbg_resp_rdata_r;
  assign dbg_resp_err   = dbg_resp_err_r;
`else
  logic unused_dbg_s;
  assign unused_dbg_s   = ^{dbg_req_valid, dbg_req_func, dbg_req_addr, dbg_req_wdata,
                            1'(STARVE_MAX % 2)};
  assign core_grant_s   = core_req_valid;
  assign dbg_grant_s    = 1'b0;
  assign core_req_ready = 1'b1;
  assign dbg_req_ready  = 1'b0;
  assign dbg_resp_valid = 1'b0;
  assign dbg_resp_rdata = {XLEN{1'b0}};
  assign dbg_resp_err   = 1'b0;
`endif

  assign accept_s        = core_grant_s | dbg_grant_s;
  assign core_resp_valid = core_resp_valid_r;
  assign core_resp_rdata = core_resp_rdata_r;
  assign core_resp_err   = core_resp_err_r;
  assign priv_mode       = status_r[1:0];
  assign csr_status      = status_r;
  assign csr_cycle       = cycle_r;

  // mux the granted request onto the shared datapath
  always_comb begin
    sel_func_s  = csr_func_e'(core_req_func);
    sel_addr_s  = core_req_addr;
    sel_wdata_s = core_req_wdata;
`ifdef CPU_AD48_CSR_DBG_PORT_EN
    if (dbg_grant_s) begin
      sel_func_s  = csr_func_e'(dbg_req_func);
      sel_addr_s  = dbg_req_addr;
      sel_wdata_s = dbg_req_wdata;
    end else begin
      sel_func_s  = csr_func_e'(core_req_func);
      sel_addr_s  = core_req_addr;
      sel_wdata_s = core_req_wdata;
    end
`endif
  end

  // read old value, compute the modified value and the WARL-filtered STATUS value
  always_comb begin
    case (sel_addr_s)
      CSR_ADDR_STATUS:  old_s = status_r;
      CSR_ADDR_SCRATCH: old_s = scratch_r;
      CSR_ADDR_CYCLE:   old_s = cycle_r;
      CSR_ADDR_INSTRET: old_s = instret_r;
      default:          old_s = {XLEN{1'b0}};
    endcase
    case (sel_func_s)
      CSR_F_RW: new_s = sel_wdata_s;
      CSR_F_RS: new_s = old_s | sel_wdata_s;
      CSR_F_RC: new_s = old_s & ~sel_wdata_s;
      default:  new_s = old_s;
    endcase
    err_s   = !csr_addr_valid(sel_addr_s) ||
              ((sel_func_s != CSR_F_R) && csr_addr_ro(sel_addr_s));
    wr_en_s = accept_s && !err_s && (sel_func_s != CSR_F_R);
    status_new_s = new_s;
    // reserved privilege encoding leaves the current mode in place
    if (new_s[1:0] == PRIV_RSVD) begin
      status_new_s[1:0] = status_r[1:0];
    end else begin
      status_new_s[1:0] = new_s[1:0];
    end
  end

  // CSR state and free-running counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_r  <= STATUS_RESET;
      scratch_r <= {XLEN{1'b0}};
      cycle_r   <= {XLEN{1'b0}};
      instret_r <= {XLEN{1'b0}};
    end else begin
      cycle_r <= cycle_r + XLEN'(1);
      if (retire) instret_r <= instret_r + XLEN'(1);
      if (wr_en_s && (sel_addr_s == CSR_ADDR_STATUS)) status_r <= status_new_s;
      if (wr_en_s && (sel_addr_s == CSR_ADDR_SCRATCH)) scratch_r <= new_s;
    end
  end

  // registered responses, one cycle after accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_resp_valid_r <= 1'b0;
      core_resp_err_r   <= 1'b0;
      core_resp_rdata_r <= {XLEN{1'b0}};
`ifdef CPU_AD48_CSR_DBG_PORT_EN
      dbg_resp_valid_r  <= 1'b0;
      dbg_resp_err_r    <= 1'b0;
      dbg_resp_rdata_r  <= {XLEN{1'b0}};
`endif
    end else begin
      core_resp_valid_r <= core_grant_s;
      core_resp_err_r   <= core_grant_s && err_s;
      core_resp_rdata_r <= (core_grant_s && !err_s) ? old_s : {XLEN{1'b0}};
`ifdef CPU_AD48_CSR_DBG_PORT_EN
      dbg_resp_valid_r  <= dbg_grant_s;
      dbg_resp_err_r    <= dbg_grant_s && err_s;
      dbg_resp_rdata_r  <= (dbg_grant_s && !err_s) ? old_s : {XLEN{1'b0}};
`endif
    end
  end

endmodule

// File: tb/tb_cpu_ad48_csr_ctrl.sv
// Self-checking bench for cpu_ad48_csr_ctrl: vector table plus scoreboard queues of responses.
module tb_cpu_ad48_csr_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        core_req_valid = 1'b0, core_req_ready;
  logic [1:0]  core_req_func = 2'd0;
  logic [11:0] core_req_addr = 12'h0;
  logic [47:0] core_req_wdata = 48'h0;
  logic        core_resp_valid, core_resp_err;
  logic [47:0] core_resp_rdata;
  logic        dbg_req_valid = 1'b0, dbg_req_ready;
  logic [1:0]  dbg_req_func = 2'd0;
  logic [11:0] dbg_req_addr = 12'h0;
  logic [47:0] dbg_req_wdata = 48'h0;
  logic        dbg_resp_valid, dbg_resp_err;
  logic [47:0] dbg_resp_rdata;
  logic        retire = 1'b0;
  logic [1:0]  priv_mode;
  logic [47:0] csr_status, csr_cycle;

  cpu_ad48_csr_ctrl dut (
    .clk(clk), .resetn(resetn),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_func(core_req_func), .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_resp_valid(core_resp_valid), .core_resp_rdata(core_resp_rdata), .core_resp_err(core_resp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_func(dbg_req_func), .dbg_req_addr(dbg_req_addr), .dbg_req_wdata(dbg_req_wdata),
    .dbg_resp_valid(dbg_resp_valid), .dbg_resp_rdata(dbg_resp_rdata), .dbg_resp_err(dbg_resp_err),
    .retire(retire), .priv_mode(priv_mode), .csr_status(csr_status), .csr_cycle(csr_cycle)
  );

  always #5 clk = ~clk;

  // reference cycle counter
  logic [47:0] cyc_model;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc_model <= 48'h0;
    else cyc_model <= cyc_model + 48'd1;
  end

  typedef struct packed { logic err; logic [47:0] rdata; } exp_t;
  typedef struct { logic [1:0] f; logic [11:0] a; logic [47:0] wd; logic [47:0] er; logic ee; } vec_t;

  exp_t core_q[$];
  exp_t dbg_q[$];
  int   tests = 0;
  int   fails = 0;
  vec_t tbl[17];
  logic [47:0] scratch_exp;
  logic exp_core;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance to the next negedge and retire any response due this cycle
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (core_resp_valid) begin
      if (core_q.size() == 0) begin
        check("core_resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = core_q.pop_front();
        check("core_rdata", core_resp_rdata, e.rdata);
        check("core_err", core_resp_err, e.err);
      end
    end else if (core_q.size() != 0) begin
      check("core_resp_missing", 64'd0, 64'd1);
      void'(core_q.pop_front());
    end
    if (dbg_resp_valid) begin
      if (dbg_q.size() == 0) begin
        check("dbg_resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = dbg_q.pop_front();
        check("dbg_rdata", dbg_resp_rdata, e.rdata);
        check("dbg_err", dbg_resp_err, e.err);
      end
    end else if (dbg_q.size() != 0) begin
      check("dbg_resp_missing", 64'd0, 64'd1);
      void'(dbg_q.pop_front());
    end
  endtask

  task automatic idle();
    tick();
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    retire         = 1'b0;
  endtask

  task automatic core_op(input logic [1:0] f, input logic [11:0] a, input logic [47:0] wd,
                         input logic [47:0] er, input logic ee, input logic ret);
    tick();
    core_req_valid = 1'b1;
    core_req_func  = f;
    core_req_addr  = a;
    core_req_wdata = wd;
    dbg_req_valid  = 1'b0;
    retire         = ret;
    #1;
    check("core_ready", core_req_ready, 1'b1);
    core_q.push_back({ee, er});
  endtask

  initial begin
    tbl[0]  = '{2'd0, 12'h000, 48'h0,            48'h3,       1'b0};
    tbl[1]  = '{2'd1, 12'h001, 48'h12340,        48'h0,       1'b0};
    tbl[2]  = '{2'd2, 12'h001, 48'h0000F,        48'h12340,   1'b0};
    tbl[3]  = '{2'd3, 12'h001, 48'h0000F,        48'h1234F,   1'b0};
    tbl[4]  = '{2'd0, 12'h001, 48'h0,            48'h12340,   1'b0};
    tbl[5]  = '{2'd1, 12'hC00, 48'h5,            48'h0,       1'b1};
    tbl[6]  = '{2'd0, 12'h3FF, 48'h0,            48'h0,       1'b1};
    tbl[7]  = '{2'd2, 12'h123, 48'h1,            48'h0,       1'b1};
    tbl[8]  = '{2'd0, 12'h001, 48'h0,            48'h12340,   1'b0};
    tbl[9]  = '{2'd0, 12'h000, 48'h0,            48'h3,       1'b0};
    tbl[10] = '{2'd1, 12'h000, 48'h123002,       48'h3,       1'b0};
    tbl[11] = '{2'd0, 12'h000, 48'h0,            48'h123003,  1'b0};
    tbl[12] = '{2'd1, 12'h000, 48'h000001,       48'h123003,  1'b0};
    tbl[13] = '{2'd0, 12'h000, 48'h0,            48'h1,       1'b0};
    tbl[14] = '{2'd3, 12'hC02, 48'h0,            48'h0,       1'b1};
    tbl[15] = '{2'd1, 12'h001, 48'hFFFFFFFFFFFF, 48'h12340,   1'b0};
    tbl[16] = '{2'd0, 12'h001, 48'h0,            48'hFFFFFFFFFFFF, 1'b0};
    scratch_exp = 48'hFFFFFFFFFFFF;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_resp_valid", core_resp_valid, 1'b0);
    check("rst_rdata", core_resp_rdata, 48'h0);
    check("rst_priv", priv_mode, 2'b11);
    check("rst_status", csr_status, 48'h3);
    check("rst_cycle", csr_cycle, 48'h0);
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      core_op(tbl[i].f, tbl[i].a, tbl[i].wd, tbl[i].er, tbl[i].ee, 1'b0);
    end
    idle();
    check("cycle_live", csr_cycle, cyc_model);
    check("priv_after_tbl", priv_mode, 2'b01);

    // priv_mode follows a STATUS write from the next cycle
    core_op(2'd1, 12'h000, 48'h3, 48'h1, 1'b0, 1'b0);
    idle();
    check("priv_m_next", priv_mode, 2'b11);
    core_op(2'd1, 12'h000, 48'h1, 48'h3, 1'b0, 1'b0);
    idle();
    check("priv_s_next", priv_mode, 2'b01);
    core_op(2'd1, 12'h000, 48'hF00002, 48'h1, 1'b0, 1'b0);
    core_op(2'd0, 12'h000, 48'h0, 48'hF00001, 1'b0, 1'b0);
    idle();
    check("priv_rsvd_kept", priv_mode, 2'b01);

    // INSTRET: ten retires, then a read concurrent with a retire
    tick();
    retire = 1'b1;
    repeat (10) tick();
    retire = 1'b0;
    core_op(2'd0, 12'hC02, 48'h0, 48'd10, 1'b0, 1'b1);
    core_op(2'd0, 12'hC02, 48'h0, 48'd11, 1'b0, 1'b0);

    // back-to-back CYCLE reads track the reference counter
    for (int k = 0; k < 2; k++) begin
      tick();
      core_req_valid = 1'b1;
      core_req_func  = 2'd0;
      core_req_addr  = 12'hC00;
      retire         = 1'b0;
      #1;
      core_q.push_back({1'b0, cyc_model});
    end
    idle();

`ifdef CPU_AD48_CSR_DBG_PORT_EN
    // contention: four core wins then one forced debug grant
    for (int k = 0; k < 10; k++) begin
      tick();
      core_req_valid = 1'b1; core_req_func = 2'd0; core_req_addr = 12'h001;
      dbg_req_valid  = 1'b1; dbg_req_func  = 2'd0; dbg_req_addr  = 12'h001;
      #1;
      exp_core = ((k % 5) != 4);
      check("arb_core_ready", core_req_ready, exp_core);
      check("arb_dbg_ready", dbg_req_ready, !exp_core);
      if (exp_core) core_q.push_back({1'b0, scratch_exp});
      else dbg_q.push_back({1'b0, scratch_exp});
    end
    idle();
    tick();
    dbg_req_valid = 1'b1; dbg_req_func = 2'd1; dbg_req_addr = 12'h001; dbg_req_wdata = 48'h55;
    #1;
    check("dbg_alone_ready", dbg_req_ready, 1'b1);
    dbg_q.push_back({1'b0, scratch_exp});
    scratch_exp = 48'h55;
    idle();
    core_op(2'd0, 12'h001, 48'h0, scratch_exp, 1'b0, 1'b0);
    idle();
`else
    // debug port absent: never ready, requests ignored
    tick();
    core_req_valid = 1'b1; core_req_func = 2'd0; core_req_addr = 12'h001;
    dbg_req_valid  = 1'b1; dbg_req_func  = 2'd1; dbg_req_addr  = 12'h001; dbg_req_wdata = 48'h55;
    #1;
    check("nodbg_dbg_ready", dbg_req_ready, 1'b0);
    check("nodbg_core_ready", core_req_ready, 1'b1);
    core_q.push_back({1'b0, scratch_exp});
    tick();
    core_req_valid = 1'b0;
    #1;
    check("nodbg_dbg_ready_alone", dbg_req_ready, 1'b0);
    idle();
    core_op(2'd0, 12'h001, 48'h0, scratch_exp, 1'b0, 1'b0);
    idle();
`endif

    // reset right after accept drops the in-flight response and the write
    core_op(2'd1, 12'h001, 48'hABC, scratch_exp, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    core_req_valid = 1'b0;
    core_q.delete();
    #1;
    check("midrst_resp_valid", core_resp_valid, 1'b0);
    check("midrst_status", csr_status, 48'h3);
    check("midrst_cycle", csr_cycle, 48'h0);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    core_op(2'd0, 12'h001, 48'h0, 48'h0, 1'b0, 1'b0);
    core_op(2'd0, 12'h000, 48'h0, 48'h3, 1'b0, 1'b0);
    idle();
    idle();
    check("queue_drained", core_q.size() + dbg_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
